// File: rtl/sum_display.sv
// sum_display: captures a 5-bit adder sum, converts it to two BCD digits with
// an iterative shift-and-add-3 (double-dabble) FSM, and time-multiplexes the
// digits onto a common-anode 7-segment display (active-low segments/anodes).
module sum_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  // Conversion register layout: {tens[3:0], ones[3:0], bin[4:0]}.
  state_e      state_q;
  logic [12:0] shift_q;
  logic [12:0] adj_d;
  logic [12:0] shift_d;
  logic [2:0]  count_q;
  logic        busy_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;

  logic [CW-1:0] refresh_q;
  logic          sel_q;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD is blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      default: seg_pattern = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    adj_d = shift_q;
    if (shift_q[12:9] >= 4'd5) adj_d[12:9] = shift_q[12:9] + 4'd3;
    if (shift_q[8:5]  >= 4'd5) adj_d[8:5]  = shift_q[8:5]  + 4'd3;
    shift_d = {adj_d[11:0], 1'b0};
  end

  // Conversion FSM: capture on load, five dabble steps, then publish digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the digit registers are reset too, so an aborted conversion never reaches the display.
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q <= {8'd0, sum};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          // load and sum are deliberately ignored here; nothing is queued.
          shift_q <= shift_d;
          count_q <= count_q + 3'd1;
          if (count_q == 3'd4) begin
            tens_q  <= shift_d[12:9];
            ones_q  <= shift_d[8:5];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-running refresh counter; flips the digit select on every wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      sel_q     <= 1'b0;
    end else if (refresh_q == REFRESH_LAST) begin
      refresh_q <= '0;
      sel_q     <= ~sel_q;
    end else begin
      refresh_q <= refresh_q + CW'(1);
    end
  end

  // Digit mux with leading-zero blanking of the tens position.
  always_comb begin
    an  = 4'b1110;
    seg = seg_pattern(ones_q);
    if (sel_q) begin
      if (tens_q != 4'd0) begin
        an  = 4'b1101;
        seg = seg_pattern(tens_q);
      end else begin
        an  = 4'b1111;
        seg = 7'b1111111;
      end
    end
  end

  assign busy = busy_q;
  assign dp   = 1'b1;

endmodule

// File: doc/sum_display.md
# sum_display

Downstream display stage for the 4-bit adder's 5-bit sum. On a load strobe it captures the sum and converts it to two BCD digits with an iterative shift-and-add-3 (double-dabble) state machine. It then time-multiplexes the digits onto a common-anode 7-segment display, with active-low segments and anodes. It sits between the adder output and the board's display pins.

## Interface
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the mux advances; minimum 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- sum  input  5  unsigned adder result, 0..31.
- load  input  1  capture request; sampled on rising edge of clk.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  segment drive, active-low; bit order {g,f,e,d,c,b,a}.
- an  output  4  anode enables, active-low; an[0] is ones, an[1] is tens, an[3:2] always 1.
- dp  output  1  decimal point, active-low; held 1 (off).

## Operation
- States:
  - IDLE: waits for load.
  - CONV: conversion in progress.
- IDLE, load=1:
  - Load shift register {tens[3:0], ones[3:0], bin[4:0]} = {8'd0, sum}.
  - Set iteration count to 0, busy to 1, and move to CONV.
- IDLE, load=0: hold all state.
- CONV, each cycle:
  - Add 3 to any BCD nibble ≥ 5.
  - Shift the whole register left by 1.
  - Increment the count.
- CONV, 5th iteration (count==4):
  - Write the shifted nibbles to the displayed digit registers tens_q and ones_q.
  - Clear busy and return to IDLE.
- load while in CONV is ignored; it is not queued. sum changes during CONV have no effect.
- Conversion results: tens_q ∈ 0..3, ones_q ∈ 0..9, and the pair equals the captured sum in decimal.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 continuously, regardless of FSM state.
  - On wrap to 0, toggle the digit select sel.
- Display outputs:
  - sel=0: an=4'b1110, seg=pattern(ones_q).
  - sel=1, tens_q≠0: an=4'b1101, seg=pattern(tens_q).
  - sel=1, tens_q=0: leading-zero blank, an=4'b1111 and seg=7'b1111111.
- Patterns, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble: 1111111.
- The displayed digits change only at the end of a conversion. During CONV the previous value stays visible.
- seg and an are combinational from registered sel, tens_q and ones_q.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE, busy=0, count=0, tens_q=0, ones_q=0.
  - Refresh counter 0, sel=0.
  - Outputs an=4'b1110, seg=7'b1000000, dp=1.
- Latency:
  - load high at edge k enters CONV; busy=1 after edge k.
  - Digits update at edge k+5; busy=0 after edge k+5.
  - busy is high for exactly 5 cycles.
- Back-to-back loads: a load held high continuously restarts at edge k+6. Maximum throughput is one conversion per 6 cycles.
- Digit period: sel toggles every REFRESH_DIV cycles, so the full frame is 2·REFRESH_DIV cycles.
- Reset mid-conversion:
  - Aborts immediately to the reset values.
  - The partially converted value is never displayed.
- The refresh counter and conversion FSM are independent. A digit update at the same edge as a sel toggle is legal and displays the new digits immediately.

## Test plan
Run all scenarios with REFRESH_DIV=4.
- Reset: assert rst mid-run -> busy=0, an=1110, seg=1000000, dp=1. Hold for 10 cycles -> sel alternates; tens is blanked (an=1111) in sel=1 phases.
- Conversion 30: sum=30, load 1 cycle -> busy high for exactly 5 cycles. Then sel=0 shows an=1110 with seg=1000000 ("0"); sel=1 shows an=1101 with seg=0110000 ("3").
- Exhaustive: sum=0..31 each loaded after busy falls -> {tens_q, ones_q} decodes to the decimal of sum for every value. 9 shows ones=0010000 with tens blank; 10 shows tens=1111001 and ones=1000000.
- Load during busy: load sum=7, then pulse load with sum=15 two cycles later -> the second load is ignored and the display shows 7 (ones=1111000, tens blank).
- Reset mid-conversion: load sum=25, assert rst at cycle 3 of busy -> digits read 0, busy=0. A new load with sum=12 after reset -> tens "1" and ones "2" (0100100).
- Refresh timing: count cycles between anode changes -> exactly 4. an[3:2]=11 and dp=1 on every cycle.
